// File: rtl/rob_retire.sv
// In-order retirement buffer: records renamed instructions in program order,
// retires one done head entry per cycle and returns its superseded physical register.
module rob_retire #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_has_rd,
  input  logic [4:0]       disp_rd,
  input  logic [5:0]       disp_pd,
  input  logic [5:0]       disp_old_pd,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic             flush,
  output logic             retire_valid,
  output logic [4:0]       retire_rd,
  output logic [5:0]       retire_pd,
  output logic             free_valid,
  output logic [5:0]       free_preg,
  output logic [TAG_W:0]   count,
  output logic             empty
);

  typedef struct packed {
    logic       has_rd;
    logic [4:0] rd;
    logic [5:0] pd;
    logic [5:0] old_pd;
  } entry_t;

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W + 1)'(1);

  entry_t           mem [DEPTH];
  entry_t           head_entry;
  logic [DEPTH-1:0] valid_q, done_q, valid_next, done_next;
  logic [TAG_W:0]   head_q, tail_q;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, disp_fire, retire_fire, cmpl_fire;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  // Extra wrap bit distinguishes full (same index, different lap) from empty.
  assign full       = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign empty      = (head_q == tail_q);
  assign count      = tail_q - head_q;
  assign disp_ready = !full;
  assign disp_tag   = tail_idx;
  assign head_entry = mem[head_idx];

  assign disp_fire   = disp_valid && !full;
  assign retire_fire = valid_q[head_idx] && done_q[head_idx];
  assign cmpl_fire   = cmpl_valid && valid_q[cmpl_tag] &&
                       !(disp_fire && (cmpl_tag == tail_idx));

  always_comb begin
    // NOTE: defaults first so every path assigns both vectors; otherwise latches are inferred.
    valid_next = valid_q;
    done_next  = done_q;
    if (retire_fire) valid_next[head_idx] = 1'b0;
    if (cmpl_fire)   done_next[cmpl_tag]  = 1'b1;
    // Dispatch is applied last so a fresh entry always starts not-done.
    if (disp_fire) begin
      valid_next[tail_idx] = 1'b1;
      done_next[tail_idx]  = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      retire_valid <= 1'b0;
      free_valid   <= 1'b0;
      retire_rd    <= '0;
      retire_pd    <= '0;
      free_preg    <= '0;
    end else if (flush) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      retire_valid <= 1'b0;
      free_valid   <= 1'b0;
    end else begin
      valid_q      <= valid_next;
      done_q       <= done_next;
      retire_valid <= retire_fire;
      free_valid   <= retire_fire && head_entry.has_rd;
      if (retire_fire) begin
        head_q    <= head_q + PTR_ONE;
        retire_rd <= head_entry.rd;
        retire_pd <= head_entry.pd;
        free_preg <= head_entry.old_pd;
      end
      if (disp_fire) tail_q <= tail_q + PTR_ONE;
    end
  end

  // NOTE: payload storage has no reset; it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (disp_fire) mem[tail_idx] <= '{has_rd: disp_has_rd, rd: disp_rd,
                                      pd: disp_pd, old_pd: disp_old_pd};
  end

endmodule
